// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: reset PC default, fault instruction word,
// and the layout of one buffered fetch entry {fault, pc[31:0], ins[31:0]}.
// No ports; imported by the fetch interface, FIFO and top.
package fetch_unit_pkg;

  localparam logic [31:0] FETCH_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] FETCH_FAULT_INS = 32'h0000_0000;

  // Packed MSB-first: fault at bit 64, pc at [63:32], ins at [31:0].
  typedef struct packed {
    logic        fault;
    logic [31:0] pc;
    logic [31:0] ins;
  } fetch_entry_t;

  localparam int FETCH_ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: imem request/response, PC redirect and decode output.
// Latency: none (wires only).
// Backpressure: imem_req_ready stalls requests, out_ready stalls decode output; responses cannot stall.
interface fetch_unit_if;

  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_ins;
  logic [31:0] out_pc;
  logic [31:0] out_pc_4;
  logic        out_fault;

  // master: the fetch unit itself
  modport master (
    output imem_req_valid, imem_req_addr, out_valid, out_ins, out_pc, out_pc_4, out_fault,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, out_ready
  );

  // slave: imem, redirect source and decoder seen from outside
  modport slave (
    input  imem_req_valid, imem_req_addr, out_valid, out_ins, out_pc, out_pc_4, out_fault,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, out_ready
  );

endinterface

// File: rtl/fetch_unit_fifo.sv
// Synchronous FIFO of fetch entries; ports push/pop/flush in, dat/full/empty/count out.
// Latency: 1 cycle push-to-visible; head read combinationally.
// Backpressure: none internally; flush dominates push and pop, push+pop allowed when full.
module fetch_unit_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [WIDTH-1:0]           dat_i,
  output logic [WIDTH-1:0]           dat_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign dat_o   = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  // A push into a full FIFO only lands if the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_q <= count_q + CW'(1);
      else if (do_pop && !do_push) count_q <= count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= dat_i;
  end

  overflow_chk: assert property (@(posedge clk) disable iff (!rst_n)
    !(push_i && full_o && !pop_i && !flush_i));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues in-order imem reads, buffers responses for decode.
// Latency: accept in N, response in N+k, out_valid in N+k+1. Ports: clk, rst_n, bus (master).
// Backpressure: outstanding+buffered capped at DEPTH, so out_ready=0 stops requests; redirect flushes.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = FETCH_RESET_PC,
  parameter int          DEPTH    = 2            // power of two, >= 2
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);

  localparam int            CW      = $clog2(DEPTH+1);
  localparam int            IW      = CW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;     // PC belonging to the next kept response
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;
  logic          halted_q, halted_d;
  logic          fpend_q, fpend_d;       // misaligned fault waiting for stale responses

  logic [CW-1:0] fifo_cnt;
  logic          fifo_full, fifo_empty;
  fetch_entry_t  push_dat, fifo_head, head;
  logic          push, pop, accept, rsp, misaligned;
  logic [IW-1:0] inflight;

  assign inflight   = {1'b0, outst_q} + {1'b0, fifo_cnt};
  assign misaligned = (bus.redirect_pc[1:0] != 2'b00);

  // rst_n gates valid so the request line is low for the whole reset window.
  assign bus.imem_req_valid = rst_n && !halted_q && !bus.redirect_valid && (inflight < IW'(DEPTH));
  assign bus.imem_req_addr  = pc_q;
  assign accept             = bus.imem_req_valid && bus.imem_req_ready;
  // A response with nothing outstanding belongs to a fetch issued before reset.
  assign rsp                = bus.imem_rsp_valid && (outst_q != '0);
  assign pop                = !fifo_empty && bus.out_ready && !bus.redirect_valid;

  always_comb begin
    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    outst_d  = outst_q;
    drop_d   = drop_q;
    halted_d = halted_q;
    fpend_d  = fpend_q;
    push     = 1'b0;
    push_dat = '0;

    if (accept && !rsp && outst_q != DEPTH_C) outst_d = outst_q + CW'(1);
    else if (!accept && rsp)                  outst_d = outst_q - CW'(1);

    if (bus.redirect_valid) begin
      pc_d     = bus.redirect_pc;
      rsp_pc_d = bus.redirect_pc;
      // Everything still in flight is stale, including a response arriving now.
      drop_d   = rsp ? outst_q - CW'(1) : outst_q;
      halted_d = misaligned;
      fpend_d  = misaligned;
    end else begin
      if (accept) pc_d = pc_q + 32'd4;
      if (rsp) begin
        if (drop_q != '0) begin
          drop_d = drop_q - CW'(1);
        end else begin
          push         = 1'b1;
          push_dat.ins = bus.imem_rsp_data;
          push_dat.pc  = rsp_pc_q;
          rsp_pc_d     = rsp_pc_q + 32'd4;
        end
      end else if (fpend_q && drop_q == '0) begin
        // Halted, so no kept response can compete with the fault entry.
        push           = 1'b1;
        push_dat.fault = 1'b1;
        push_dat.pc    = rsp_pc_q;
        push_dat.ins   = FETCH_FAULT_INS;
        fpend_d        = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      outst_q  <= '0;
      drop_q   <= '0;
      halted_q <= 1'b0;
      fpend_q  <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      outst_q  <= outst_d;
      drop_q   <= drop_d;
      halted_q <= halted_d;
      fpend_q  <= fpend_d;
    end
  end

  fetch_unit_fifo #(
    .WIDTH (FETCH_ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (bus.redirect_valid),
    .dat_i   (push_dat),
    .dat_o   (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  // Zero the outputs when empty so idle/reset values are well defined.
  assign head          = fifo_empty ? '0 : fifo_head;
  assign bus.out_valid = !fifo_empty;
  assign bus.out_ins   = head.ins;
  assign bus.out_pc    = head.pc;
  assign bus.out_pc_4  = head.pc + 32'd4;
  assign bus.out_fault = head.fault;

  full_no_req: assert property (@(posedge clk) disable iff (!rst_n)
    fifo_full |-> !bus.imem_req_valid);

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int passed = 0;

  // Instruction memory model: fixed latency, in order, data tagged by address.
  int          cyc = 0;
  int          lat = 1;
  logic [31:0] salt = 32'h0;
  logic        model_clr = 1'b0;
  logic [31:0] q_addr[$];
  logic [31:0] q_dat[$];
  int          q_due[$];

  logic [31:0] got_pc[$];
  logic [31:0] got_ins[$];
  logic [31:0] got_pc4[$];
  logic        got_fault[$];

  function automatic logic [31:0] ins_of(input logic [31:0] a);
    return 32'hC0DE_0000 | {16'h0, a[15:0]};
  endfunction

  always @(clk) begin
    if (clk) begin
      cyc = cyc + 1;
      if (rst_n && bus.imem_req_valid && bus.imem_req_ready) begin
        q_addr.push_back(bus.imem_req_addr);
        q_dat.push_back(ins_of(bus.imem_req_addr) ^ salt);
        q_due.push_back(cyc + lat - 1);
      end
    end else begin
      if (model_clr) begin
        q_addr.delete(); q_dat.delete(); q_due.delete();
      end
      if (q_addr.size() > 0 && cyc >= q_due[0]) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = q_dat[0];
        void'(q_addr.pop_front()); void'(q_dat.pop_front()); void'(q_due.pop_front());
      end else begin
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.imem_req_ready = 1'b0; bus.out_ready = 1'b0;
    bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0;
    lat = 1; salt = 32'h0; model_clr = 1'b1;
    step(); step();
    model_clr = 1'b0;
    step();
  endtask

  // Records decode handshakes; comparisons are done by the caller.
  task automatic collect(input int n, input int bound);
    got_pc.delete(); got_ins.delete(); got_pc4.delete(); got_fault.delete();
    for (int s = 0; s < bound && got_pc.size() < n; s++) begin
      if (bus.out_valid && bus.out_ready) begin
        got_pc.push_back(bus.out_pc); got_ins.push_back(bus.out_ins);
        got_pc4.push_back(bus.out_pc_4); got_fault.push_back(bus.out_fault);
      end
      step();
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.imem_req_valid !== 1'b0) $display("FAIL rst_req_valid got %b want 0", bus.imem_req_valid); else passed++;
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid got %b want 0", bus.out_valid); else passed++;
    checks++; if (bus.out_fault !== 1'b0) $display("FAIL rst_out_fault got %b want 0", bus.out_fault); else passed++;
    checks++; if (bus.out_ins !== 32'h0) $display("FAIL rst_out_ins got %h want 0", bus.out_ins); else passed++;
    checks++; if (bus.out_pc !== 32'h0) $display("FAIL rst_out_pc got %h want 0", bus.out_pc); else passed++;
    checks++; if (bus.out_pc_4 !== 32'h4) $display("FAIL rst_out_pc_4 got %h want 4", bus.out_pc_4); else passed++;
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc [3] = '{32'h0, 32'h4, 32'h8};
    logic [31:0] exp_ins[3] = '{32'hC0DE_0000, 32'hC0DE_0004, 32'hC0DE_0008};
    logic [31:0] exp_p4 [3] = '{32'h4, 32'h8, 32'hC};
    logic [31:0] issued[$];
    int first = -1;
    do_reset();
    bus.imem_req_ready = 1'b1; bus.out_ready = 1'b1;
    rst_n = 1'b1;
    #1;
    got_pc.delete(); got_ins.delete(); got_pc4.delete();
    for (int s = 0; s < 40 && got_pc.size() < 3; s++) begin
      if (bus.out_valid && first < 0) first = s;
      if (bus.imem_req_valid && bus.imem_req_ready && issued.size() < 3) issued.push_back(bus.imem_req_addr);
      if (bus.out_valid && bus.out_ready) begin
        got_pc.push_back(bus.out_pc); got_ins.push_back(bus.out_ins); got_pc4.push_back(bus.out_pc_4);
      end
      step();
    end
    checks++; if (first !== 2) $display("FAIL stream_first_valid_cycle got %0d want 2", first); else passed++;
    checks++; if (got_pc.size() !== 3 || issued.size() !== 3) $display("FAIL stream_count got %0d/%0d want 3/3", got_pc.size(), issued.size()); else passed++;
    if (got_pc.size() == 3 && issued.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (issued[i] !== exp_pc[i]) $display("FAIL stream_req_addr[%0d] got %h want %h", i, issued[i], exp_pc[i]); else passed++;
        checks++; if (got_pc[i] !== exp_pc[i]) $display("FAIL stream_out_pc[%0d] got %h want %h", i, got_pc[i], exp_pc[i]); else passed++;
        checks++; if (got_ins[i] !== exp_ins[i]) $display("FAIL stream_out_ins[%0d] got %h want %h", i, got_ins[i], exp_ins[i]); else passed++;
        checks++; if (got_pc4[i] !== exp_p4[i]) $display("FAIL stream_out_pc_4[%0d] got %h want %h", i, got_pc4[i], exp_p4[i]); else passed++;
      end
    end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    logic [31:0] exp_pc[3] = '{32'h0, 32'h4, 32'h8};
    do_reset();
    bus.imem_req_ready = 1'b1;
    rst_n = 1'b1;
    #1;
    for (int s = 0; s < 5; s++) begin
      if (bus.imem_req_valid && bus.imem_req_ready) acc++;
      if (s < 4) step();
    end
    checks++; if (acc !== 2) $display("FAIL bp_accepted got %0d want 2", acc); else passed++;
    checks++; if (bus.imem_req_valid !== 1'b0) $display("FAIL bp_req_valid got %b want 0", bus.imem_req_valid); else passed++;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0) $display("FAIL bp_head got v=%b pc=%h want v=1 pc=0", bus.out_valid, bus.out_pc); else passed++;
    bus.out_ready = 1'b1;
    #1;
    collect(3, 40);
    checks++; if (got_pc.size() !== 3) $display("FAIL bp_count got %0d want 3", got_pc.size()); else passed++;
    if (got_pc.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (got_pc[i] !== exp_pc[i]) $display("FAIL bp_order[%0d] got %h want %h", i, got_pc[i], exp_pc[i]); else passed++;
      end
    end
  endtask

  task automatic test_redirect_flush();
    do_reset();
    lat = 3;
    bus.imem_req_ready = 1'b1; bus.out_ready = 1'b1;
    rst_n = 1'b1;
    step(); step();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h100;
    #1;
    checks++; if (bus.imem_req_valid !== 1'b0) $display("FAIL rf_req_in_redirect got %b want 0", bus.imem_req_valid); else passed++;
    step();
    bus.redirect_valid = 1'b0;
    #1;
    collect(1, 30);
    checks++; if (got_pc.size() !== 1) $display("FAIL rf_count got %0d want 1", got_pc.size()); else passed++;
    if (got_pc.size() == 1) begin
      checks++; if (got_pc[0] !== 32'h100) $display("FAIL rf_first_pc got %h want 00000100", got_pc[0]); else passed++;
      checks++; if (got_ins[0] !== 32'hC0DE_0100) $display("FAIL rf_first_ins got %h want c0de0100", got_ins[0]); else passed++;
    end
  endtask

  task automatic test_redirect_same_cycle();
    do_reset();
    bus.imem_req_ready = 1'b1; bus.out_ready = 1'b1;
    rst_n = 1'b1;
    step(); step();
    checks++; if (bus.out_valid !== 1'b1 || bus.imem_rsp_valid !== 1'b1) $display("FAIL sc_setup got v=%b rsp=%b want 1/1", bus.out_valid, bus.imem_rsp_valid); else passed++;
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h100;
    step();
    bus.redirect_valid = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL sc_flushed got %b want 0", bus.out_valid); else passed++;
    checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h100) $display("FAIL sc_next_req got v=%b a=%h want 1/00000100", bus.imem_req_valid, bus.imem_req_addr); else passed++;
    collect(1, 20);
    checks++; if (got_pc.size() !== 1 || got_pc[0] !== 32'h100) $display("FAIL sc_next_pc got n=%0d want pc 00000100", got_pc.size()); else passed++;
  endtask

  task automatic test_misaligned();
    int viol = 0;
    do_reset();
    bus.imem_req_ready = 1'b1; bus.out_ready = 1'b1;
    rst_n = 1'b1;
    step();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h102;
    #1;
    checks++; if (bus.imem_req_valid !== 1'b0) $display("FAIL mis_req_in_redirect got %b want 0", bus.imem_req_valid); else passed++;
    step();
    bus.redirect_valid = 1'b0;
    #1;
    checks++; if (bus.imem_req_valid !== 1'b0) $display("FAIL mis_halted_req got %b want 0", bus.imem_req_valid); else passed++;
    collect(1, 10);
    checks++; if (got_pc.size() !== 1) $display("FAIL mis_count got %0d want 1", got_pc.size()); else passed++;
    if (got_pc.size() == 1) begin
      checks++; if (got_fault[0] !== 1'b1) $display("FAIL mis_fault got %b want 1", got_fault[0]); else passed++;
      checks++; if (got_ins[0] !== 32'h0) $display("FAIL mis_ins got %h want 0", got_ins[0]); else passed++;
      checks++; if (got_pc[0] !== 32'h102) $display("FAIL mis_pc got %h want 00000102", got_pc[0]); else passed++;
      checks++; if (got_pc4[0] !== 32'h106) $display("FAIL mis_pc_4 got %h want 00000106", got_pc4[0]); else passed++;
    end
    for (int s = 0; s < 5; s++) begin
      if (bus.out_valid || bus.imem_req_valid) viol++;
      step();
    end
    checks++; if (viol !== 0) $display("FAIL mis_idle got %0d busy cycles want 0", viol); else passed++;
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h200;
    step();
    bus.redirect_valid = 1'b0;
    #1;
    collect(1, 20);
    checks++; if (got_pc.size() !== 1 || got_pc[0] !== 32'h200 || got_ins[0] !== 32'hC0DE_0200 || got_fault[0] !== 1'b0)
      $display("FAIL mis_resume got n=%0d want pc 00000200 ins c0de0200 fault 0", got_pc.size()); else passed++;
  endtask

  task automatic test_pc_wrap();
    logic [31:0] exp_pc [2] = '{32'hFFFF_FFFC, 32'h0};
    logic [31:0] exp_p4 [2] = '{32'h0, 32'h4};
    logic [31:0] exp_ins[2] = '{32'hC0DE_FFFC, 32'hC0DE_0000};
    do_reset();
    bus.imem_req_ready = 1'b1; bus.out_ready = 1'b1;
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hFFFF_FFFC;
    rst_n = 1'b1;
    step();
    bus.redirect_valid = 1'b0;
    #1;
    collect(2, 30);
    checks++; if (got_pc.size() !== 2) $display("FAIL wrap_count got %0d want 2", got_pc.size()); else passed++;
    if (got_pc.size() == 2) begin
      for (int i = 0; i < 2; i++) begin
        checks++; if (got_pc[i] !== exp_pc[i] || got_pc4[i] !== exp_p4[i] || got_ins[i] !== exp_ins[i])
          $display("FAIL wrap[%0d] got pc=%h pc4=%h ins=%h want %h %h %h", i, got_pc[i], got_pc4[i], got_ins[i], exp_pc[i], exp_p4[i], exp_ins[i]); else passed++;
      end
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    lat = 4; salt = 32'hDEAD_0000;
    bus.imem_req_ready = 1'b1;
    rst_n = 1'b1;
    step(); step();
    bus.imem_req_ready = 1'b0;
    step(); step(); step();
    checks++; if (bus.out_valid !== 1'b1 || bus.imem_rsp_valid !== 1'b1) $display("FAIL mr_setup got v=%b rsp=%b want 1/1", bus.out_valid, bus.imem_rsp_valid); else passed++;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL mr_out_valid got %b want 0", bus.out_valid); else passed++;
    checks++; if (bus.out_ins !== 32'h0 || bus.out_pc !== 32'h0) $display("FAIL mr_out_data got ins=%h pc=%h want 0/0", bus.out_ins, bus.out_pc); else passed++;
    checks++; if (bus.out_pc_4 !== 32'h4) $display("FAIL mr_out_pc_4 got %h want 4", bus.out_pc_4); else passed++;
    rst_n = 1'b1;
    step();
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL mr_late_rsp got %b want 0", bus.out_valid); else passed++;
    salt = 32'h0;
    bus.imem_req_ready = 1'b1; bus.out_ready = 1'b1;
    #1;
    collect(1, 20);
    checks++; if (got_pc.size() !== 1 || got_pc[0] !== 32'h0 || got_ins[0] !== 32'hC0DE_0000)
      $display("FAIL mr_restart got n=%0d want pc 0 ins c0de0000", got_pc.size()); else passed++;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.imem_req_ready = 1'b0; bus.out_ready = 1'b0;
    bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_flush();
    test_redirect_same_cycle();
    test_misaligned();
    test_pc_wrap();
    test_reset_midstream();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
